// File: rtl/ps2_rx_queue.sv
// PS/2 receiver with de-glitched clock qualification, frame time-out, keyboard prefix folding
// and a first-word-fall-through entry FIFO with sticky error flags.
module ps2_rx_queue #(
  parameter int FILTER_HI = 4,
  parameter int FILTER_LO = 12,
  parameter int TIMEOUT   = 16777215,
  parameter int FIFO_AW   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_rcv,
  input  logic               kb_or_mouse,
  input  logic               ps2clk_ext,
  input  logic               ps2data_ext,
  input  logic               rd_en,
  input  logic               clr_err,
  output logic [9:0]         dout,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   count,
  output logic               kb_interrupt,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overflow
);

  localparam int HW    = FILTER_HI + FILTER_LO;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [HW-1:0]    hist_q;
  state_t           state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             ext_q, ext_d, rel_q, rel_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0] count_q, count_d;
  logic [9:0]       mem_q [DEPTH];
  logic             kb_int_q, par_err_q, frm_err_q, ovf_q;

  logic       qual_edge, din;
  logic       push, push_ok, pop;
  logic [9:0] push_data;
  logic       par_err_set, frm_err_set;

  // Qualified edge: long-enough high history followed by a long-enough low run.
  assign qual_edge = (&hist_q[HW-1:FILTER_LO]) & ~(|hist_q[FILTER_LO-1:0]);
  assign din       = dat_s2_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    push        = 1'b0;
    push_data   = '0;
    par_err_set = 1'b0;
    frm_err_set = 1'b0;
    tmo_d       = (state_q == IDLE || qual_edge) ? '0 : tmo_q + TW'(1);

    if (!enable_rcv) begin
      state_d = IDLE;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT)) begin
      state_d     = IDLE;
      ext_d       = 1'b0;
      rel_d       = 1'b0;
      frm_err_set = 1'b1;
    end else if (qual_edge) begin
      case (state_q)
        IDLE: begin
          if (!din) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shreg_d  = {din, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          if (^{shreg_q, din}) begin
            state_d = STOP;
          end else begin
            state_d     = IDLE;
            par_err_set = 1'b1;
          end
        end
        STOP: begin
          state_d = IDLE;
          if (!din) begin
            frm_err_set = 1'b1;
          end else if (kb_or_mouse) begin
            push      = 1'b1;
            push_data = {2'b00, shreg_q};
          end else if (shreg_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shreg_q == 8'hF0) begin
            rel_d = 1'b1;
          end else begin
            push      = 1'b1;
            push_data = {ext_q, rel_q, shreg_q};
            ext_d     = 1'b0;
            rel_d     = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a push when the same cycle pops.
  assign pop     = rd_en && (count_q != '0);
  assign push_ok = push && ((count_q != FULL_CNT) || pop);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1_q  <= 1'b0;
      clk_s2_q  <= 1'b0;
      dat_s1_q  <= 1'b0;
      dat_s2_q  <= 1'b0;
      hist_q    <= '0;
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
      tmo_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      kb_int_q  <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      clk_s1_q  <= ps2clk_ext;
      clk_s2_q  <= clk_s1_q;
      dat_s1_q  <= ps2data_ext;
      dat_s2_q  <= dat_s1_q;
      hist_q    <= {hist_q[HW-2:0], clk_s2_q};
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      ext_q     <= ext_d;
      rel_q     <= rel_d;
      tmo_q     <= tmo_d;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      count_q   <= count_d;
      kb_int_q  <= push_ok;
      // A fresh error in the clearing cycle wins over clr_err.
      par_err_q <= (par_err_q & ~clr_err) | par_err_set;
      frm_err_q <= (frm_err_q & ~clr_err) | frm_err_set;
      ovf_q     <= (ovf_q & ~clr_err) | (push & ~push_ok);
    end
  end

  assign dout         = (count_q == '0) ? 10'h000 : mem_q[rptr_q];
  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_CNT);
  assign count        = count_q;
  assign kb_interrupt = kb_int_q;
  assign parity_err   = par_err_q;
  assign frame_err    = frm_err_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_rx_queue.sv
// Directed bench for ps2_rx_queue: frames are bit-banged on the PS/2 pins, results checked
// against hand-computed entries, counts and flags.
module tb_ps2_rx_queue;

  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       rst_n, enable_rcv, kb_or_mouse, ps2clk_ext, ps2data_ext, rd_en, clr_err;
  logic [9:0] dout;
  logic       empty, full, kb_interrupt, parity_err, frame_err, overflow;
  logic [3:0] count;

  int n_checks = 0;
  int n_errs   = 0;
  int irq_cnt  = 0;
  int irq_base = 0;

  always #5 clk = ~clk;

  ps2_rx_queue #(
    .FILTER_HI(4), .FILTER_LO(12), .TIMEOUT(1000), .FIFO_AW(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_rcv(enable_rcv), .kb_or_mouse(kb_or_mouse),
    .ps2clk_ext(ps2clk_ext), .ps2data_ext(ps2data_ext), .rd_en(rd_en), .clr_err(clr_err),
    .dout(dout), .empty(empty), .full(full), .count(count), .kb_interrupt(kb_interrupt),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always @(posedge clk) if (kb_interrupt) irq_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One PS/2 bit: data set while clock high, then a low phase; optional pop on the edge cycle.
  task automatic ps2_bit(input logic b, input logic pop_on_edge);
    ps2data_ext = b;
    repeat (HALF) @(negedge clk);
    ps2clk_ext = 1'b0;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clk);
      rd_en = pop_on_edge && (i == 14);
    end
    ps2clk_ext = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit,
                            input logic pop_on_stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit((~^b) ^ bad_par, 1'b0);
    ps2_bit(stop_bit, pop_on_stop);
    ps2data_ext = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0);
    ps2data_ext = 1'b1;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int waited;
    rst_n = 1'b0; enable_rcv = 1'b0; kb_or_mouse = 1'b0;
    ps2clk_ext = 1'b1; ps2data_ext = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 10'h000);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 0);
    check("rst_irq", kb_interrupt, 1'b0);
    check("rst_errs", {parity_err, frame_err, overflow}, 3'b000);
    rst_n = 1'b1;

    // Receiver disabled: nothing is captured.
    irq_base = irq_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("dis_count", count, 0);
    check("dis_irq", irq_cnt - irq_base, 0);
    enable_rcv = 1'b1;

    // Keyboard single byte.
    irq_base = irq_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("kb_1c_irq", irq_cnt - irq_base, 1);
    check("kb_1c_dout", dout, 10'h01C);
    check("kb_1c_count", count, 1);
    pop_one();
    check("kb_1c_popped", empty, 1'b1);

    // Extended release prefix folding.
    irq_base = irq_cnt;
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check("pfx_irq", irq_cnt - irq_base, 1);
    check("pfx_dout", dout, 10'h375);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check("pfx_count2", count, 2);
    check("pfx_head_kept", dout, 10'h375);
    pop_one();
    check("pfx_plain", dout, 10'h075);
    pop_one();
    check("pfx_empty", empty, 1'b1);

    // Parity and stop-bit errors.
    irq_base = irq_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("par_err", parity_err, 1'b1);
    check("par_nopush", count, 0);
    pulse_clr();
    check("par_cleared", parity_err, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("stop_frame_err", frame_err, 1'b1);
    check("stop_nopush", count, 0);
    check("err_irq", irq_cnt - irq_base, 0);
    pulse_clr();
    check("stop_cleared", frame_err, 1'b0);

    // Fill past full, then pop on the same cycle as a push into a full FIFO.
    irq_base = irq_cnt;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
    check("fill_count", count, 8);
    check("fill_full", full, 1'b1);
    check("fill_ovf", overflow, 1'b1);
    check("fill_head", dout, 10'h001);
    check("fill_irq", irq_cnt - irq_base, 8);
    irq_base = irq_cnt;
    send_frame(8'h0A, 1'b0, 1'b1, 1'b1);
    check("rw_count", count, 8);
    check("rw_irq", irq_cnt - irq_base, 1);
    check("rw_head", dout, 10'h002);
    for (int i = 0; i < 7; i++) pop_one();
    check("rw_last", dout, 10'h00A);
    check("rw_last_cnt", count, 1);
    pop_one();
    check("rw_empty", empty, 1'b1);
    pulse_clr();
    check("ovf_cleared", overflow, 1'b0);

    // Time-out mid-frame; pending E0 must be discarded with it.
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_partial(8'h1C, 3);
    check("tmo_not_yet", frame_err, 1'b0);
    waited = 0;
    while (!frame_err && waited < 1500) begin
      @(negedge clk);
      waited++;
    end
    check("tmo_frame_err", frame_err, 1'b1);
    check("tmo_latency", (waited >= 900 && waited <= 1100), 1'b1);
    check("tmo_nopush", count, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("tmo_recover", dout, 10'h01C);
    pop_one();
    pulse_clr();

    // Mouse mode: raw bytes.
    kb_or_mouse = 1'b1;
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h08, 1'b0, 1'b1, 1'b0);
    check("mouse_count", count, 2);
    check("mouse_e0", dout, 10'h0E0);
    pop_one();
    check("mouse_08", dout, 10'h008);
    pop_one();

    // Reset in the middle of a frame.
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_partial(8'h1C, 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_empty", empty, 1'b1);
    check("mrst_dout", dout, 10'h000);
    check("mrst_flags", {parity_err, frame_err, overflow}, 3'b000);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("mrst_recover", dout, 10'h01C);
    check("mrst_noerr", {parity_err, frame_err, overflow}, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
